// File: rtl/timer_seq_pkg.sv
// Shared types and default sizes for the long_timer echo-train sequencer.
package timer_seq_pkg;

    localparam int PARA_W_DEF = 16;
    localparam int CNT_W_DEF  = 8;
    localparam int WDOG_W_DEF = 24;
    localparam logic [WDOG_W_DEF-1:0] WDOG_LIMIT_DEF = 24'hFFFFFF;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        RUN_W,
        LOAD_A,
        RUN_A,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/seg_watchdog.sv
// Rising-edge detector for long_timer's timeup level plus a per-segment
// saturating watchdog that runs only while a segment is being timed.
module seg_watchdog
    import timer_seq_pkg::*;
#(
    parameter int                WDOG_W     = WDOG_W_DEF,
    parameter logic [WDOG_W-1:0] WDOG_LIMIT = {WDOG_W{1'b1}}
) (
    input  logic clk_sys,
    input  logic rst,
    input  logic clr,
    input  logic run,
    input  logic timeup,
    output logic tu_edge,
    output logic expired
);

    logic              timeup_d;
    logic [WDOG_W-1:0] wdog_cnt;

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            timeup_d <= 1'b0;
            wdog_cnt <= '0;
        end else begin
            timeup_d <= timeup;
            if (clr)
                wdog_cnt <= '0;
            else if (run && (wdog_cnt != {WDOG_W{1'b1}}))
                wdog_cnt <= wdog_cnt + 1'b1;
        end
    end

    assign tu_edge = timeup & ~timeup_d;
    // Trips on the RUN cycle whose increment would reach the limit, so the
    // sequencer leaves RUN after exactly WDOG_LIMIT cycles there.
    assign expired = run && (wdog_cnt >= (WDOG_LIMIT - 1'b1));

endmodule

// File: rtl/timer_seq.sv
// Drives long_timer through repeat_num WAIT/ACQ interval pairs, one start
// pulse per non-zero interval, advancing on each rising edge of timeup.
module timer_seq
    import timer_seq_pkg::*;
#(
    parameter int                PARA_W     = PARA_W_DEF,
    parameter int                CNT_W      = CNT_W_DEF,
    parameter int                WDOG_W     = WDOG_W_DEF,
    parameter logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_LIMIT_DEF
) (
    input  logic              clk_sys,
    input  logic              rst,
    input  logic              go,
    input  logic              abort,
    input  logic [PARA_W-1:0] wait_para,
    input  logic [PARA_W-1:0] acq_para,
    input  logic [CNT_W-1:0]  repeat_num,
    input  logic              timeup,
    output logic              timer_start,
    output logic [PARA_W-1:0] timer_para,
    output logic              phase_acq,
    output logic              seg_done,
    output logic              seq_done,
    output logic              busy,
    output logic              error,
    output logic [CNT_W-1:0]  cycle_cnt
);

    state_t            state;
    logic [PARA_W-1:0] wait_lat;
    logic [PARA_W-1:0] acq_lat;
    logic [CNT_W-1:0]  rep_lat;
    logic [CNT_W-1:0]  cnt_inc;
    logic              tu_edge;
    logic              expired;
    logic              wd_clr;
    logic              wd_run;
    logic              w_end;
    logic              a_end;

    assign wd_clr  = (state == LOAD_W) || (state == LOAD_A);
    assign wd_run  = (state == RUN_W)  || (state == RUN_A);
    assign cnt_inc = cycle_cnt + 1'b1;

    // A zero-length segment ends in its LOAD cycle as though timeup had fired.
    assign w_end = ((state == LOAD_W) && (wait_lat == '0)) || ((state == RUN_W) && tu_edge);
    assign a_end = ((state == LOAD_A) && (acq_lat == '0))  || ((state == RUN_A) && tu_edge);

    seg_watchdog #(
        .WDOG_W     (WDOG_W),
        .WDOG_LIMIT (WDOG_LIMIT)
    ) u_wdog (
        .clk_sys (clk_sys),
        .rst     (rst),
        .clr     (wd_clr),
        .run     (wd_run),
        .timeup  (timeup),
        .tu_edge (tu_edge),
        .expired (expired)
    );

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wait_lat    <= '0;
            acq_lat     <= '0;
            rep_lat     <= '0;
            timer_start <= 1'b0;
            timer_para  <= '0;
            phase_acq   <= 1'b0;
            seg_done    <= 1'b0;
            seq_done    <= 1'b0;
            busy        <= 1'b0;
            error       <= 1'b0;
            cycle_cnt   <= '0;
        end else begin
            timer_start <= 1'b0;
            seg_done    <= 1'b0;
            seq_done    <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                busy      <= 1'b0;
                phase_acq <= 1'b0;
                error     <= 1'b0;
            end else if (state == IDLE) begin
                if (go) begin
                    wait_lat  <= wait_para;
                    acq_lat   <= acq_para;
                    rep_lat   <= repeat_num;
                    cycle_cnt <= '0;
                    busy      <= 1'b1;
                    if (repeat_num != '0) begin
                        state       <= LOAD_W;
                        timer_para  <= wait_para;
                        timer_start <= (wait_para != '0);
                    end else begin
                        state <= DONE;
                    end
                end
            end else if (w_end) begin
                seg_done    <= 1'b1;
                state       <= LOAD_A;
                phase_acq   <= 1'b1;
                timer_para  <= acq_lat;
                timer_start <= (acq_lat != '0);
            end else if (a_end) begin
                seg_done  <= 1'b1;
                cycle_cnt <= cnt_inc;
                phase_acq <= 1'b0;
                if (cnt_inc == rep_lat) begin
                    state <= DONE;
                end else begin
                    state       <= LOAD_W;
                    timer_para  <= wait_lat;
                    timer_start <= (wait_lat != '0);
                end
            end else if (expired) begin
                state     <= ERR;
                busy      <= 1'b0;
                phase_acq <= 1'b0;
                error     <= 1'b1;
            end else begin
                case (state)
                    LOAD_W:  state <= RUN_W;
                    LOAD_A:  state <= RUN_A;
                    DONE: begin
                        seq_done <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                    default: ;  // RUN_x waiting, or ERR holding until abort
                endcase
            end
        end
    end

endmodule

// File: tb/tb_timer_seq.sv
// Directed plus randomized checks of timer_seq against a behavioural model
// of the expected interval list, with a long_timer stand-in driving timeup.
module tb_timer_seq;

    logic        clk_sys = 1'b0;
    logic        rst;
    logic        go;
    logic        abort;
    logic [15:0] wait_para;
    logic [15:0] acq_para;
    logic [7:0]  repeat_num;
    logic        timeup;
    logic        timer_start;
    logic [15:0] timer_para;
    logic        phase_acq;
    logic        seg_done;
    logic        seq_done;
    logic        busy;
    logic        error;
    logic [7:0]  cycle_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int raise_cyc = -1;
    int tm_cnt = 0;
    int tm_dmin = 1;
    int tm_dmax = 1;
    bit tm_en = 1'b1;

    always #5 clk_sys = ~clk_sys;

    timer_seq #(
        .PARA_W     (16),
        .CNT_W      (8),
        .WDOG_W     (24),
        .WDOG_LIMIT (24'd20)
    ) dut (
        .clk_sys     (clk_sys),
        .rst         (rst),
        .go          (go),
        .abort       (abort),
        .wait_para   (wait_para),
        .acq_para    (acq_para),
        .repeat_num  (repeat_num),
        .timeup      (timeup),
        .timer_start (timer_start),
        .timer_para  (timer_para),
        .phase_acq   (phase_acq),
        .seg_done    (seg_done),
        .seq_done    (seq_done),
        .busy        (busy),
        .error       (error),
        .cycle_cnt   (cycle_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock; outputs are then sampled 1 ns past the edge. The long_timer
    // stand-in drops timeup on a start and raises it a random delay later.
    task automatic step();
        @(posedge clk_sys);
        #1;
        cyc++;
        if (tm_cnt > 0) begin
            tm_cnt--;
            if (tm_cnt == 0) begin
                timeup    = 1'b1;
                raise_cyc = cyc;
            end
        end
        if (tm_en && (timer_start === 1'b1)) begin
            timeup = 1'b0;
            tm_cnt = int'($urandom_range(tm_dmax, tm_dmin));
        end
    endtask

    task automatic start_go(input int w, input int a, input int r);
        wait_para  = 16'(w);
        acq_para   = 16'(a);
        repeat_num = 8'(r);
        go         = 1'b1;
        cyc        = 0;
        raise_cyc  = -1;
        step();
        go = 1'b0;
    endtask

    task automatic run_seq(input string name, input int w, input int a, input int r,
                           input int dmin, input int dmax, input bit disturb);
        int exp_para[$];
        bit exp_acq[$];
        int nseg = 0, nstart = 0, seq_cyc = -1, last_seg = -1, edge_exp = -1;
        int p;
        bit ph;
        for (int i = 0; i < r; i++) begin
            if (w != 0) begin exp_para.push_back(w); exp_acq.push_back(1'b0); end
            if (a != 0) begin exp_para.push_back(a); exp_acq.push_back(1'b1); end
        end
        tm_dmin = dmin;
        tm_dmax = dmax;
        start_go(w, a, r);
        while (seq_cyc < 0 && cyc < 20000) begin
            if (cyc == edge_exp)
                chk({name, ":seg_after_edge"}, seg_done, 1);
            if (timer_start === 1'b1) begin
                nstart++;
                chk({name, ":extra_start"}, (exp_para.size() > 0), 1);
                if (exp_para.size() > 0) begin
                    p  = exp_para.pop_front();
                    ph = exp_acq.pop_front();
                    chk({name, ":start_para"}, timer_para, p);
                    chk({name, ":start_phase"}, phase_acq, ph);
                end
                if (nstart == 1 && w != 0)
                    chk({name, ":first_start_cycle"}, cyc, 1);
                chk({name, ":start_latency"}, (cyc == 1) || (seg_done === 1'b1), 1);
            end
            if (seg_done === 1'b1) begin
                nseg++;
                last_seg = cyc;
                chk({name, ":cnt_at_seg"}, cycle_cnt, nseg / 2);
            end
            if (seq_done === 1'b1)
                seq_cyc = cyc;
            if (raise_cyc == cyc)
                edge_exp = cyc + 1;
            if (disturb && busy === 1'b1 && ($urandom % 4) == 0) begin
                go         = 1'b1;
                wait_para  = 16'($urandom);
                acq_para   = 16'($urandom);
                repeat_num = 8'($urandom);
            end else begin
                go = 1'b0;
            end
            step();
        end
        go = 1'b0;
        chk({name, ":seq_seen"}, (seq_cyc >= 0), 1);
        chk({name, ":seg_count"}, nseg, 2 * r);
        chk({name, ":starts_left"}, exp_para.size(), 0);
        chk({name, ":cycle_cnt"}, cycle_cnt, r);
        chk({name, ":busy_after"}, busy, 0);
        chk({name, ":seq_once"}, seq_done, 0);
        if (r == 0)
            chk({name, ":seq_cycle"}, seq_cyc, 2);
        else
            chk({name, ":seq_cycle"}, seq_cyc, last_seg + 1);
        $display("run %s w=%0d a=%0d r=%0d starts=%0d segs=%0d seq_cycle=%0d",
                 name, w, a, r, nstart, nseg, seq_cyc);
    endtask

    initial begin
        int w, a, r, d;
        int nstart;
        bit hit;
        bit stray;
        rst        = 1'b1;
        go         = 1'b0;
        abort      = 1'b0;
        timeup     = 1'b0;
        wait_para  = '0;
        acq_para   = '0;
        repeat_num = '0;
        step();
        step();
        chk("rst:timer_start", timer_start, 0);
        chk("rst:timer_para", timer_para, 0);
        chk("rst:busy", busy, 0);
        chk("rst:error", error, 0);
        chk("rst:cycle_cnt", cycle_cnt, 0);
        chk("rst:pulses", {phase_acq, seg_done, seq_done}, 0);
        rst = 1'b0;
        step();

        run_seq("normal", 3, 5, 2, 3, 3, 1'b0);
        run_seq("rep0", 7, 9, 0, 1, 4, 1'b0);
        run_seq("acq0", 4, 0, 3, 1, 5, 1'b0);
        run_seq("wait0", 0, 6, 2, 1, 5, 1'b0);
        run_seq("both0", 0, 0, 3, 1, 1, 1'b0);
        run_seq("rep255", 2, 1, 255, 1, 1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            w = (($urandom % 3) == 0) ? 0 : int'($urandom_range(1000, 1));
            a = (($urandom % 3) == 0) ? 0 : int'($urandom_range(1000, 1));
            r = int'($urandom_range(4, 0));
            d = int'($urandom_range(6, 1));
            run_seq($sformatf("rand%0d", k), w, a, r, 1, d, 1'b1);
        end

        // abort together with the ACQ timeup of the second pair
        tm_dmin = 2;
        tm_dmax = 5;
        start_go(4, 4, 3);
        nstart = 0;
        hit = 1'b0;
        while (!hit && cyc < 300) begin
            if (timer_start === 1'b1) nstart++;
            if (nstart == 4 && raise_cyc == cyc) begin
                hit = 1'b1;
                chk("abort:in_acq", phase_acq, 1);
                chk("abort:cnt_before", cycle_cnt, 1);
                abort = 1'b1;
            end
            step();
        end
        abort = 1'b0;
        chk("abort:reached", hit, 1);
        chk("abort:busy", busy, 0);
        chk("abort:timer_start", timer_start, 0);
        chk("abort:phase", phase_acq, 0);
        stray = seg_done | seq_done;
        for (int k = 0; k < 4; k++) begin
            step();
            stray = stray | seg_done | seq_done | timer_start;
        end
        chk("abort:no_pulses", stray, 0);
        chk("abort:cnt_held", cycle_cnt, 1);
        $display("run abort starts=%0d cycle_cnt=%0d", nstart, cycle_cnt);

        // watchdog: timeup never answers
        tm_en  = 1'b0;
        timeup = 1'b0;
        start_go(7, 7, 1);
        chk("wdog:start", timer_start, 1);
        while (cyc < 21) step();
        chk("wdog:not_yet", error, 0);
        step();
        chk("wdog:error", error, 1);
        chk("wdog:busy", busy, 0);
        go = 1'b1;
        step();
        go = 1'b0;
        step();
        chk("wdog:go_ignored_busy", busy, 0);
        chk("wdog:go_ignored_start", timer_start, 0);
        chk("wdog:error_sticky", error, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("wdog:abort_clears", error, 0);
        tm_en = 1'b1;
        $display("run watchdog error_cycle=22");
        run_seq("after_wdog", 5, 3, 1, 1, 3, 1'b0);

        // asynchronous reset in the middle of a WAIT segment
        tm_dmin = 8;
        tm_dmax = 8;
        start_go(6, 6, 2);
        step();
        step();
        chk("rstmid:busy_before", busy, 1);
        #2;
        rst    = 1'b1;
        tm_cnt = 0;
        #1;
        chk("rstmid:busy", busy, 0);
        chk("rstmid:timer_para", timer_para, 0);
        chk("rstmid:outs", {timer_start, phase_acq, seg_done, seq_done, error}, 0);
        chk("rstmid:cycle_cnt", cycle_cnt, 0);
        step();
        rst = 1'b0;
        step();
        $display("run reset_mid_run");
        run_seq("after_rst", 3, 5, 2, 1, 4, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/timer_seq.md
Name: timer_seq

Overview:
Initiator-side controller for the long_timer start/timeup interface in the clock-management domain. On a `go` command it runs an NMR echo train of alternating WAIT and ACQ intervals, `repeat_num` times. For each interval it drives `timer_para` and pulses `timer_start`, then waits for the rising edge of `timeup`. A watchdog flags a timer that never answers.

Parameters:
- PARA_W, 16, width of the interval values sent on timer_para
- CNT_W, 8, width of the repeat count and the cycle counter
- WDOG_W, 24, width of the watchdog counter (clk_sys cycles)
- WDOG_LIMIT, 24'hFFFFFF, clk_sys cycles allowed per segment before error

Ports:
- clk_sys  in  1  system clock; same clock as long_timer
- rst  in  1  asynchronous, active-high reset
- go  in  1  one-cycle start-sequence request
- abort  in  1  one-cycle cancel; returns to IDLE from any state
- wait_para  in  PARA_W  WAIT interval value
- acq_para  in  PARA_W  ACQ interval value
- repeat_num  in  CNT_W  number of WAIT+ACQ pairs
- timeup  in  1  long_timer expiry level
- timer_start  out  1  one-cycle start pulse to long_timer
- timer_para  out  PARA_W  interval value to long_timer
- phase_acq  out  1  1 while in the ACQ segment
- seg_done  out  1  one-cycle pulse at the end of each segment
- seq_done  out  1  one-cycle pulse when the sequence completes
- busy  out  1  high in any state other than IDLE or ERR
- error  out  1  sticky watchdog error
- cycle_cnt  out  CNT_W  number of completed pairs

Behaviour:
- Reset: all outputs are 0; state = IDLE; latched parameters = 0.
- `timeup` is same-domain, so it is not synchronised. `tu_edge = timeup & ~timeup_d`, where `timeup_d` is `timeup` registered once.
- States: IDLE, LOAD_W, RUN_W, LOAD_A, RUN_A, DONE, ERR.
- IDLE:
  - `go` sampled at cycle 0 latches `wait_para`, `acq_para` and `repeat_num`, and clears `cycle_cnt`.
  - If `repeat_num` != 0: go to LOAD_W.
  - If `repeat_num` == 0: go to DONE.
- LOAD_x (one cycle):
  - `timer_para` = latched value for that segment; it is registered and held until the next LOAD.
  - `timer_start` = 1 during this cycle only.
  - The watchdog is cleared.
  - Next state is RUN_x.
  - First `timer_start` is in cycle 1 after `go`.
- Zero-length segment: if the latched value for the segment is 0, LOAD_x issues no `timer_start`. It pulses `seg_done` and advances as if `tu_edge` had occurred.
- RUN_W:
  - On `tu_edge`: `seg_done` = 1 for one cycle, next state LOAD_A.
  - If the watchdog reaches WDOG_LIMIT: go to ERR.
- RUN_A:
  - On `tu_edge`: `seg_done` = 1 and `cycle_cnt`++.
  - If the new `cycle_cnt` == `repeat_num`: go to DONE; otherwise go to LOAD_W.
  - Watchdog rule is the same as RUN_W.
- Edge-to-start latency: `tu_edge` in cycle T gives `timer_start` in cycle T+1.
- `tu_edge` is ignored in IDLE, LOAD_x, DONE and ERR; no queuing.
- DONE: `seq_done` = 1 for one cycle, then IDLE.
- ERR: `error` = 1 and `busy` = 0. `go` is ignored. Only `abort` or `rst` clears `error` and returns to IDLE.
- `phase_acq` = 1 in LOAD_A and RUN_A, else 0.
- `busy` is registered and mirrors state: 1 in LOAD_x, RUN_x and DONE.
- `go` while `busy` is ignored; latched parameters are not disturbed.
- `abort`:
  - Takes priority over every other event in the same cycle.
  - Next cycle: state = IDLE, `busy` = 0, `timer_start` = 0.
  - No `seg_done` or `seq_done` is issued.
  - `cycle_cnt` holds its value for readback.
- `cycle_cnt` saturates at repeat_num; `repeat_num` = 255 runs 255 pairs with no wrap.
- Watchdog: WDOG_W-bit counter, incremented only in RUN_x, saturating.

Decomposition:
- `timer_seq_pkg`: state enum, PARA_W, CNT_W and WDOG_W defaults, WDOG_LIMIT constant.
- One sub-module, `seg_watchdog`: owns the `timeup` edge detector and the watchdog counter. Inputs: clk_sys, rst, clr, run, timeup. Outputs: tu_edge, expired.

Test Plan:
- Normal run: wait_para=3, acq_para=5, repeat_num=2, long_timer model returns timeup N cycles after start.
  - Expect 4 `timer_start` pulses, with `timer_para` = 3,5,3,5 in that order.
  - Expect 4 `seg_done` pulses, then `seq_done` once, and `cycle_cnt` = 2.
- Latency: `go` at cycle 0 gives `timer_start` in cycle 1; `tu_edge` at cycle T gives the next `timer_start` at T+1.
- Zero cases:
  - repeat_num=0: `seq_done` at cycle 2, no `timer_start`.
  - acq_para=0: only WAIT starts are issued, and `seg_done` still pulses twice per pair.
- Abort: `abort` asserted in the same cycle as `tu_edge` during RUN_A gives IDLE next cycle, no `seg_done`, `cycle_cnt` unchanged.
- Watchdog: WDOG_LIMIT=20 and `timeup` held low.
  - `error` = 1 after 20 RUN cycles; `go` is then ignored.
  - `abort` clears `error`.
- Reset mid-run: assert `rst` during RUN_W. All outputs go to 0 immediately (async); after release the block is in IDLE and accepts a new `go`.
